vga_output_stage: RTL

- Sits directly downstream of the controlled pipeline and consumes its pixel stream: pixel, x, y and ready.
- Buffers the stream in a small FIFO and generates VGA timing (800x600@60, 40 MHz pixel clock).
- Drives RGB and sync pins aligned to the timing.
- Detects underrun, overflow and position mismatch, and resynchronises to the start of a frame after any fault.

---
 rtl/vga_output_stage.sv | 107 ++++++++++
 1 files changed

// File: rtl/vga_output_stage.sv
// vga_output_stage: FIFO-buffered pixel stream to VGA timing with fault detection and frame resync
module vga_output_stage #(
  parameter int R_WIDTH = 5,
  parameter int G_WIDTH = 6,
  parameter int B_WIDTH = 5,
  parameter int PRECISION = 11,
  parameter int RESOLUTION_X = 800,
  parameter int RESOLUTION_Y = 600,
  parameter int H_FRONT_PORCH = 40,
  parameter int H_SYNC = 128,
  parameter int H_BACK_PORCH = 88,
  parameter int V_FRONT_PORCH = 1,
  parameter int V_SYNC = 4,
  parameter int V_BACK_PORCH = 23,
  parameter logic SYNC_POLARITY = 1'b1,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int START_THRESHOLD = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic [R_WIDTH+G_WIDTH+B_WIDTH-1:0] pixel_in,
  input  logic [PRECISION-1:0] pixel_x_in,
  input  logic [PRECISION-1:0] pixel_y_in,
  input  logic pixel_ready_in,
  input  logic status_clear,
  output logic [R_WIDTH-1:0] vga_r,
  output logic [G_WIDTH-1:0] vga_g,
  output logic [B_WIDTH-1:0] vga_b,
  output logic vga_hsync,
  output logic vga_vsync,
  output logic vga_active,
  output logic underrun,
  output logic overflow,
  output logic position_error,
  output logic [FIFO_DEPTH_LOG2:0] fifo_level
);
  localparam int PW = R_WIDTH + G_WIDTH + B_WIDTH;
  localparam int EW = 2 * PRECISION + PW;
  localparam int LW = FIFO_DEPTH_LOG2 + 1;
  localparam int H_TOTAL = RESOLUTION_X + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
  localparam int V_TOTAL = RESOLUTION_Y + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;
  localparam logic [PRECISION-1:0] H_ACT = PRECISION'(RESOLUTION_X);
  localparam logic [PRECISION-1:0] V_ACT = PRECISION'(RESOLUTION_Y);
  localparam logic [PRECISION-1:0] H_LAST = PRECISION'(H_TOTAL - 1);
  localparam logic [PRECISION-1:0] V_LAST = PRECISION'(V_TOTAL - 1);
  localparam logic [PRECISION-1:0] HS_ON = PRECISION'(RESOLUTION_X + H_FRONT_PORCH);
  localparam logic [PRECISION-1:0] HS_OFF = PRECISION'(RESOLUTION_X + H_FRONT_PORCH + H_SYNC);
  localparam logic [PRECISION-1:0] VS_ON = PRECISION'(RESOLUTION_Y + V_FRONT_PORCH);
  localparam logic [PRECISION-1:0] VS_OFF = PRECISION'(RESOLUTION_Y + V_FRONT_PORCH + V_SYNC);
  localparam logic [LW-1:0] FULL_LVL = LW'(1 << FIFO_DEPTH_LOG2);
  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
  state_t state, state_nx;
  logic [PRECISION-1:0] h, v;
  logic [EW-1:0] mem [1 << FIFO_DEPTH_LOG2];
  logic [LW-1:0] wr_ptr, rd_ptr;
  logic [EW-1:0] head;
  logic empty, full, active, start, push, pop, under_f, over_f, pos_f, fault, hs, vs;
  assign fifo_level = wr_ptr - rd_ptr;
  always_comb begin
    head = mem[rd_ptr[FIFO_DEPTH_LOG2-1:0]];
    empty = fifo_level == '0;
    full = fifo_level == FULL_LVL;
    active = state == RUN && h < H_ACT && v < V_ACT;
    start = state == IDLE && pixel_ready_in && pixel_x_in == '0 && pixel_y_in == '0;
    pop = active && !empty;
    under_f = active && empty;
    over_f = state != IDLE && pixel_ready_in && full && !pop;
    push = start || (state != IDLE && pixel_ready_in && !over_f);
    pos_f = pop && head[EW-1 -: 2*PRECISION] != {h, v};
    fault = under_f || over_f || pos_f;
    hs = state == RUN && h >= HS_ON && h < HS_OFF;
    vs = state == RUN && v >= VS_ON && v < VS_OFF;
    state_nx = fault ? IDLE :
               start ? FILL :
               (state == FILL && int'(fifo_level) >= START_THRESHOLD) ? RUN : state;
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= {pixel_x_in, pixel_y_in, pixel_in};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      h <= '0;
      v <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      {vga_r, vga_g, vga_b} <= '0;
      vga_active <= 1'b0;
      vga_hsync <= ~SYNC_POLARITY;
      vga_vsync <= ~SYNC_POLARITY;
      underrun <= 1'b0;
      overflow <= 1'b0;
      position_error <= 1'b0;
    end else begin
      state <= state_nx;
      wr_ptr <= fault ? '0 : wr_ptr + LW'(push);
      rd_ptr <= fault ? '0 : rd_ptr + LW'(pop);
      h <= (state != RUN || fault || h == H_LAST) ? '0 : h + 1'b1;
      v <= (state != RUN || fault) ? '0 : (h != H_LAST) ? v : (v == V_LAST) ? '0 : v + 1'b1;
      {vga_r, vga_g, vga_b} <= pop ? head[PW-1:0] : '0;
      vga_active <= active;
      vga_hsync <= hs ? SYNC_POLARITY : ~SYNC_POLARITY;
      vga_vsync <= vs ? SYNC_POLARITY : ~SYNC_POLARITY;
      underrun <= under_f || (underrun && !status_clear);
      overflow <= over_f || (overflow && !status_clear);
      position_error <= pos_f || (position_error && !status_clear);
    end
  end
endmodule
